pic_rom_arbiter: RTL
====================

PIC_ROM_ARBITER -- requirements
Module: pic_rom_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 15: VGA-won cycles (1..15) an AUX request waits before it is forced through.
REQ-002 SHALL have port vgaclk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports vga_req/aux_req  in  1 each  per-cycle read request from the display path / auxiliary loader.
REQ-005 SHALL have ports vga_addr/aux_addr  in  8, vga_index/aux_index  in  4, vga_inv/aux_inv  in  1: requester pixel address, picture index, invert flag.
REQ-006 SHALL have ports rom_addr  out  8, rom_index  out  4, rom_inv  out  1: registered picture-ROM drive.
REQ-007 SHALL have port rom_data  in  12  picture-ROM read data, valid one cycle after rom_* are presented.
REQ-008 SHALL have ports vga_gnt/aux_gnt  out  1 each  owner of the ROM in the current cycle.
REQ-009 SHALL have ports vga_valid/aux_valid  out  1 each, rd_data  out  12: registered return data tagged to its requester.

Function
REQ-010 SHALL hold a state register with states IDLE, GNT_VGA, GNT_AUX, updated every edge from requests sampled at that edge.
REQ-011 SHALL select next state: aux_forced (REQ-016) -> GNT_AUX; else vga_req -> GNT_VGA; else aux_req -> GNT_AUX; else IDLE.
REQ-012 SHALL, on entering GNT_x, load rom_addr/rom_index/rom_inv from requester x's inputs at the same edge; in IDLE hold previous rom_* values.
REQ-013 SHALL drive vga_gnt = (state==GNT_VGA), aux_gnt = (state==GNT_AUX); never both high.
REQ-014 SHALL pipeline owner tag two stages: request high in cycle 0 -> gnt in cycle 1 -> rom_data valid cycle 2 -> rd_data <= rom_data and x_valid high in cycle 3 (fixed 3-cycle latency, one result per cycle, back-to-back).
REQ-015 SHALL keep rd_data unchanged and both valids low in cycles following IDLE slots.
REQ-016 SHALL (ARB_STARVE_EN) keep a 4-bit aux_wait counter: +1 on each edge where aux_req=1 and GNT_VGA is chosen; cleared on each edge where aux_req=0 or GNT_AUX is chosen; aux_forced = aux_req && aux_wait==STARVE_MAX.
REQ-017 SHALL saturate aux_wait at STARVE_MAX (no wrap).
REQ-018 SHALL, after a forced AUX slot, resume VGA priority the next cycle (forced slot is exactly one cycle).
REQ-019 SHALL treat requests as level: a requester losing arbitration receives no grant and must hold its request; no request queuing.

Reset
REQ-020 SHALL on reset set state IDLE, vga_gnt=aux_gnt=0, vga_valid=aux_valid=0, rd_data=0, rom_addr=0, rom_index=0, rom_inv=0, aux_wait=0.
REQ-021 SHALL discard all in-flight tags on reset; no valid asserts for any request sampled at or before the last reset edge.
REQ-022 SHALL ignore requests on edges where reset=1; first grant appears one cycle after the first edge with reset=0.

Configuration
REQ-023 SHALL, with macro PIC_ROM_ARB_STARVE_EN defined, implement REQ-016..REQ-018 anti-starvation.
REQ-024 SHALL, without PIC_ROM_ARB_STARVE_EN, omit aux_wait, tie aux_forced=0, and run strict VGA priority (AUX may starve indefinitely); all other behaviour identical.

Verification
REQ-025 Single VGA: vga_req=1 one cycle, vga_addr=8'h3C, index=4'h2, rom model returns 12'hABC -> vga_gnt cycle 1, rom_addr=8'h3C, vga_valid cycle 3 with rd_data=12'hABC, aux_valid stays 0.
REQ-026 Both requesting continuously, STARVE_EN defined, STARVE_MAX=15 -> 15 GNT_VGA cycles, 1 GNT_AUX, repeating; aux_valid once per 16 cycles, 3 cycles after each aux_gnt.
REQ-027 Same stimulus without STARVE_EN -> aux_gnt never asserts over 1000 cycles; vga_valid every cycle from cycle 3.
REQ-028 Alternating VGA (addr 8'h10) / AUX (addr 8'h20), 8-cycle burst -> valids alternate, each rd_data matching its address, no gap, no misrouting.
REQ-029 Reset asserted in cycle 2 of a VGA burst -> all outputs zero next cycle, no vga_valid for pre-reset requests, aux_wait=0.
REQ-030 aux_req alone after 10 lost cycles then aux_req dropped one cycle, then both requests -> aux_wait restarts from 0; forced grant only after 15 further VGA wins.

Source files
------------

// File: rtl/pic_rom_arbiter.sv
// Two-requester picture-ROM arbiter: VGA has priority over AUX, with a fixed
// 3-cycle read pipeline. Define PIC_ROM_ARB_STARVE_EN to bound AUX starvation.
module pic_rom_arbiter #(
    parameter int STARVE_MAX = 15
) (
    input  logic        vgaclk,
    input  logic        reset,
    input  logic        vga_req,
    input  logic        aux_req,
    input  logic [7:0]  vga_addr,
    input  logic [7:0]  aux_addr,
    input  logic [3:0]  vga_index,
    input  logic [3:0]  aux_index,
    input  logic        vga_inv,
    input  logic        aux_inv,
    output logic [7:0]  rom_addr,
    output logic [3:0]  rom_index,
    output logic        rom_inv,
    input  logic [11:0] rom_data,
    output logic        vga_gnt,
    output logic        aux_gnt,
    output logic        vga_valid,
    output logic        aux_valid,
    output logic [11:0] rd_data
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_VGA = 2'd1,
        GNT_AUX = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        w_aux_forced;

    logic [7:0]  r_rom_addr;
    logic [3:0]  r_rom_index;
    logic        r_rom_inv;
    logic        r_vld_vga_p1;
    logic        r_vld_aux_p1;
    logic        r_vld_vga_p2;
    logic        r_vld_aux_p2;
    logic [11:0] r_rd_data_p2;

`ifdef PIC_ROM_ARB_STARVE_EN
    localparam logic [3:0] LP_STARVE_MAX = 4'(STARVE_MAX);

    logic [3:0] r_aux_wait;

    assign w_aux_forced = aux_req && (r_aux_wait == LP_STARVE_MAX);

    // Counts consecutive VGA wins while AUX waits; saturates instead of wrapping.
    always_ff @(posedge vgaclk) begin
        if (reset) begin
            r_aux_wait <= 4'd0;
        end else if (aux_req && (w_next == GNT_VGA)) begin
            if (r_aux_wait != LP_STARVE_MAX)
                r_aux_wait <= r_aux_wait + 4'd1;
        end else begin
            r_aux_wait <= 4'd0;
        end
    end
`else
    assign w_aux_forced = 1'b0;
`endif

    always_comb begin
        w_next = IDLE;
        if (w_aux_forced)
            w_next = GNT_AUX;
        else if (vga_req)
            w_next = GNT_VGA;
        else if (aux_req)
            w_next = GNT_AUX;
    end

    always_ff @(posedge vgaclk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_rom_addr   <= 8'd0;
            r_rom_index  <= 4'd0;
            r_rom_inv    <= 1'b0;
            r_vld_vga_p1 <= 1'b0;
            r_vld_aux_p1 <= 1'b0;
            r_vld_vga_p2 <= 1'b0;
            r_vld_aux_p2 <= 1'b0;
            r_rd_data_p2 <= 12'd0;
        end else begin
            // p0: grant decision and ROM address launch
            r_state <= w_next;
            case (w_next)
                GNT_VGA: begin
                    r_rom_addr  <= vga_addr;
                    r_rom_index <= vga_index;
                    r_rom_inv   <= vga_inv;
                end
                GNT_AUX: begin
                    r_rom_addr  <= aux_addr;
                    r_rom_index <= aux_index;
                    r_rom_inv   <= aux_inv;
                end
                default: ;
            endcase

            // p1: owner tag travels while the ROM produces data
            r_vld_vga_p1 <= (r_state == GNT_VGA);
            r_vld_aux_p1 <= (r_state == GNT_AUX);

            // p2: capture ROM data for its owner; idle slots leave rd_data alone
            r_vld_vga_p2 <= r_vld_vga_p1;
            r_vld_aux_p2 <= r_vld_aux_p1;
            if (r_vld_vga_p1 || r_vld_aux_p1)
                r_rd_data_p2 <= rom_data;
        end
    end

    assign vga_gnt   = (r_state == GNT_VGA);
    assign aux_gnt   = (r_state == GNT_AUX);
    assign rom_addr  = r_rom_addr;
    assign rom_index = r_rom_index;
    assign rom_inv   = r_rom_inv;
    assign vga_valid = r_vld_vga_p2;
    assign aux_valid = r_vld_aux_p2;
    assign rd_data   = r_rd_data_p2;

endmodule
